// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading/trailing zero/one counter, valid/ready handshake.
// Define LZC_PIPE_NORM_EN to add out_norm and its normalising shifter.
module lzc_pipe #(
   parameter int WIDTH  = 23,
   parameter int STAGES = 2,
   parameter int TAGW   = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_num,
   input  logic [1:0]                 in_mode,
   input  logic [TAGW-1:0]            in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] out_cnt,
   output logic                       out_all,
`ifdef LZC_PIPE_NORM_EN
   output logic [WIDTH-1:0]           out_norm,
`endif
   output logic [TAGW-1:0]            out_tag
);

   localparam int CW = $clog2(WIDTH+1);
   localparam int LW = WIDTH - WIDTH/2;
   localparam int RW = WIDTH / 2;

   logic [WIDTH-1:0]  w_inv;
   logic [WIDTH-1:0]  w_op;
   logic [CW-1:0]     w_lcnt;
   logic [CW-1:0]     w_rcnt;
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_go;
   logic [STAGES:0]   w_vin;
   logic              w_nxt;

   // Every mode is reduced to a leading-zero count of w_op.
   always_comb begin
      w_inv = in_mode[0] ? ~in_num : in_num;
      w_op  = w_inv;
      if (in_mode[1])
         for (int i = 0; i < WIDTH; i++)
            w_op[i] = w_inv[WIDTH-1-i];
   end

   always_comb begin
      w_lcnt = CW'(LW);
      for (int i = RW; i < WIDTH; i++)
         if (w_op[i]) w_lcnt = CW'(WIDTH-1-i);
      w_rcnt = CW'(RW);
      for (int i = 0; i < RW; i++)
         if (w_op[i]) w_rcnt = CW'(RW-1-i);
   end

   // w_go[s]: stage s may load this cycle (empty, or its content leaves).
   always_comb begin
      w_nxt = out_ready;
      w_go  = '0;
      for (int s = STAGES-1; s >= 0; s--) begin
         w_go[s] = !r_vld[s] | w_nxt;
         w_nxt   = w_go[s];
      end
   end

   assign w_vin     = {r_vld, in_valid};
   assign in_ready  = w_go[0];
   assign out_valid = w_vin[STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++)
            if (w_go[s]) r_vld[s] <= w_vin[s];
      end
   end

   logic [CW-1:0]   r_lcnt;
   logic [CW-1:0]   r_rcnt;
   logic [TAGW-1:0] r_tag0;
   logic [CW-1:0]   w_cnt [STAGES];
   logic [TAGW-1:0] w_tag [STAGES];
`ifdef LZC_PIPE_NORM_EN
   logic [WIDTH-1:0] r_num;
   logic             r_lead;
   logic [WIDTH-1:0] w_norm [STAGES];
`endif

   always_ff @(posedge clk) begin
      if (in_valid & w_go[0]) begin
         r_lcnt <= w_lcnt;
         r_rcnt <= w_rcnt;
         r_tag0 <= in_tag;
`ifdef LZC_PIPE_NORM_EN
         r_num  <= in_num;
         r_lead <= !in_mode[1];
`endif
      end
   end

   assign w_cnt[0] = (r_lcnt == CW'(LW)) ? r_lcnt + r_rcnt : r_lcnt;
   assign w_tag[0] = r_tag0;
`ifdef LZC_PIPE_NORM_EN
   assign w_norm[0] = r_lead ? r_num << w_cnt[0] : r_num >> w_cnt[0];
`endif

   for (genvar g = 1; g < STAGES; g++) begin : g_stage
      logic [CW-1:0]   r_cnt;
      logic [TAGW-1:0] r_tag;
`ifdef LZC_PIPE_NORM_EN
      logic [WIDTH-1:0] r_norm;
`endif
      always_ff @(posedge clk) begin
         if (r_vld[g-1] & w_go[g]) begin
            r_cnt  <= w_cnt[g-1];
            r_tag  <= w_tag[g-1];
`ifdef LZC_PIPE_NORM_EN
            r_norm <= w_norm[g-1];
`endif
         end
      end
      assign w_cnt[g] = r_cnt;
      assign w_tag[g] = r_tag;
`ifdef LZC_PIPE_NORM_EN
      assign w_norm[g] = r_norm;
`endif
   end

   // Data flops are not reset, so outputs are forced to zero when idle.
   assign out_cnt = out_valid ? w_cnt[STAGES-1] : '0;
   assign out_all = out_valid & (w_cnt[STAGES-1] == CW'(WIDTH));
   assign out_tag = out_valid ? w_tag[STAGES-1] : '0;
`ifdef LZC_PIPE_NORM_EN
   assign out_norm = out_valid ? w_norm[STAGES-1] : '0;
`endif

endmodule
